// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker: steps a combinational block through every input
// combination, holds each one for HOLD cycles and compares the settled response.
module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_idx
);

  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;
  logic [N_OUT-1:0] exp_vec;
  logic             mismatch;

  // Expected response for the vector currently on stim.
  always_comb begin
    exp_vec  = N_OUT'(EXPECTED >> (int'(stim) * N_OUT));
    mismatch = (dut_out != exp_vec);
  end

  // Sweep sequencer; stim doubles as the vector index so it is zero outside DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      stim             <= {N_IN{1'b0}};
      hold_cnt         <= {HCW{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= {(N_IN+1){1'b0}};
      first_fail_valid <= 1'b0;
      first_fail_idx   <= {N_IN{1'b0}};
    end else if (abort) begin
      // Results are kept for debug; a pending final sample is dropped.
      state    <= ST_IDLE;
      stim     <= {N_IN{1'b0}};
      hold_cnt <= {HCW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_DRIVE;
            stim             <= {N_IN{1'b0}};
            hold_cnt         <= {HCW{1'b0}};
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= {(N_IN+1){1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_idx   <= {N_IN{1'b0}};
          end else begin
            state <= state;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= {HCW{1'b0}};
            if (mismatch) begin
              err_count <= err_count + (N_IN+1)'(1);
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= stim;
              end else begin
                first_fail_idx <= first_fail_idx;
              end
            end else begin
              err_count <= err_count;
            end
            if (stim == LAST_IDX) begin
              state <= ST_DONE;
              stim  <= {N_IN{1'b0}};
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == {(N_IN+1){1'b0}}) && !mismatch;
            end else begin
              stim <= stim + N_IN'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          stim     <= {N_IN{1'b0}};
          hold_cnt <= {HCW{1'b0}};
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: full-adder sweeps with injected faults, abort, reset and a 1-input HOLD=1 case.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] stim;
  logic [1:0] dut_out;
  logic       busy, done, pass, ffv;
  logic [3:0] err_count;
  logic [2:0] ffi;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [0:0] stim2;
  logic [0:0] dut2;
  logic       busy2, done2, pass2, ffv2;
  logic [1:0] err2;
  logic [0:0] ffi2;
  logic       invert2 = 1'b0;

  int mode = 0;
  int checks = 0;
  int errors = 0;
  int k;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(10), .EXPECTED(16'hE994)) u_fa (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_idx(ffi)
  );

  truth_table_sweeper #(.N_IN(1), .N_OUT(1), .HOLD(1), .EXPECTED(2'b10)) u_buf (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .stim(stim2),
    .dut_out(dut2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_idx(ffi2)
  );

  // Full adder {carry,sum} with selectable faults: 1 sum wrong at 5, 2 carry stuck 0, 3 sum always wrong.
  always_comb begin
    logic s, c;
    s = ^stim;
    c = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
    case (mode)
      1: if (stim == 3'd5) s = ~s;
      2: c = 1'b0;
      3: s = ~s;
      default: ;
    endcase
    dut_out = {c, s};
    dut2 = stim2 ^ invert2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a sweep and follows it until done or until cycle stop_at.
  task automatic sweep(input int stop_at, input bit poke, output int kk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    kk = 0;
    check("busy_t0", busy, 1);
    check("stim_t0", stim, 0);
    check("err_cleared", err_count, 0);
    check("ffv_cleared", ffv, 0);
    while (!done && kk < 200 && kk != stop_at) begin
      start = poke && (kk == 20 || kk == 55);
      @(negedge clk); kk++;
      start = 1'b0;
      if (kk % 10 == 5 && kk < 80) check("stim_step", stim, kk / 10);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;

    // Clean full adder
    mode = 0;
    sweep(-1, 1'b0, k);
    check("clean_latency", k, 80);
    check("clean_busy", busy, 0);
    check("clean_pass", pass, 1);
    check("clean_err", err_count, 0);
    check("clean_ffv", ffv, 0);
    repeat (5) @(negedge clk);
    check("done_sticky", done, 1);

    // Sum inverted at index 5 only
    mode = 1;
    sweep(-1, 1'b0, k);
    check("s5_latency", k, 80);
    check("s5_err", err_count, 1);
    check("s5_ffi", ffi, 5);
    check("s5_ffv", ffv, 1);
    check("s5_pass", pass, 0);
    check("s5_done", done, 1);

    // Carry stuck at 0
    mode = 2;
    sweep(-1, 1'b0, k);
    check("c0_err", err_count, 4);
    check("c0_ffi", ffi, 3);
    check("c0_pass", pass, 0);

    // Abort at cycle 35 with every vector failing: indices 0..2 already counted
    mode = 3;
    sweep(35, 1'b0, k);
    check("abort_reached", k, 35);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_stim", stim, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err_kept", err_count, 3);
    check("abort_ffv_kept", ffv, 1);
    check("abort_ffi_kept", ffi, 0);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", busy, 0);
    mode = 0;
    sweep(-1, 1'b0, k);
    check("post_abort_latency", k, 80);
    check("post_abort_pass", pass, 1);

    // Asynchronous reset at cycle 42
    mode = 3;
    sweep(42, 1'b0, k);
    check("pre_rst_err", err_count, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_stim", stim, 0);
    check("arst_err", err_count, 0);
    check("arst_ffv", ffv, 0);
    check("arst_ffi", ffi, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_restart", busy, 0);

    // Start pulses during DRIVE are ignored
    mode = 0;
    sweep(-1, 1'b1, k);
    check("poke_latency", k, 80);
    check("poke_pass", pass, 1);

    // HOLD=1 buffer: done two cycles after start
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      invert2 = (pass_no == 1);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      check("buf_busy_t0", busy2, 1);
      @(negedge clk);
      check("buf_stim1", stim2, 1);
      @(negedge clk);
      check("buf_done", done2, 1);
      check("buf_busy_fall", busy2, 0);
      check("buf_pass", pass2, pass_no == 0);
      check("buf_err", err2, pass_no == 0 ? 0 : 2);
    end
    check("buf_ffv", ffv2, 1);
    check("buf_ffi", ffi2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
